// File: rtl/aes_gcm_pkg.sv
// aes_gcm_pkg: shared phase encoding, block type and counter helpers for the GCM front end
package aes_gcm_pkg;
  typedef logic [0:127] block_t;
  typedef enum logic [0:2] {
    PH_BUBBLE = 3'd0,
    PH_INIT   = 3'd1,
    PH_AAD    = 3'd2,
    PH_PT     = 3'd3,
    PH_LEN    = 3'd4
  } phase_t;
  localparam logic [31:0] J0_SUFFIX = 32'h00000001;
  function automatic block_t inc32(input block_t b);
    return {b[0:95], b[96:127] + 32'd1};
  endfunction
  // Bit length rounded up to whole 128-bit blocks
  function automatic logic [31:0] blocks(input logic [0:63] bits);
    return 32'((bits + 64'd127) >> 7);
  endfunction
endpackage

// File: rtl/aes_gcm_issue_scheduler_if.sv
// aes_gcm_issue_scheduler_if: job/data handshakes, credit return and pipeline slot outputs
interface aes_gcm_issue_scheduler_if;
  import aes_gcm_pkg::*;
  logic i_job_valid, o_job_ready;
  logic [0:95] i_job_iv;
  logic [0:63] i_job_aad_len_bits, i_job_pt_len_bits;
  logic i_data_valid, o_data_ready;
  block_t i_data;
  logic i_credit_return, o_credit_err;
  phase_t o_phase;
  block_t o_h, o_encrypted_j0, o_encrypted_cb, o_aad, o_plain_text, o_instance_size;
  modport master (
    output i_job_valid, i_job_iv, i_job_aad_len_bits, i_job_pt_len_bits, i_data_valid, i_data, i_credit_return,
    input o_job_ready, o_data_ready, o_credit_err, o_phase, o_h, o_encrypted_j0, o_encrypted_cb, o_aad,
    o_plain_text, o_instance_size
  );
  modport slave (
    input i_job_valid, i_job_iv, i_job_aad_len_bits, i_job_pt_len_bits, i_data_valid, i_data, i_credit_return,
    output o_job_ready, o_data_ready, o_credit_err, o_phase, o_h, o_encrypted_j0, o_encrypted_cb, o_aad,
    o_plain_text, o_instance_size
  );
endinterface

// File: rtl/aes_gcm_credit_counter.sv
// aes_gcm_credit_counter: result-buffer credits, saturating at CREDITS with a sticky overflow flag
module aes_gcm_credit_counter #(
  parameter int CREDITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic consume,
  input  logic credit_return,
  output logic [$clog2(CREDITS+1)-1:0] count,
  output logic nonzero,
  output logic err
);
  localparam int W = $clog2(CREDITS + 1);
  localparam logic [W-1:0] MAX = W'(CREDITS);
  logic full;
  assign full = count == MAX;
  assign nonzero = count != '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= MAX;
      err <= 1'b0;
    end else begin
      if (consume && !credit_return) count <= count - W'(1);
      else if (credit_return && !consume && !full) count <= count + W'(1);
      if (credit_return && !consume && full) err <= 1'b1;
    end
  end
endmodule

// File: rtl/aes_gcm_issue_scheduler.sv
// aes_gcm_issue_scheduler: sequences INIT/AAD/PT/LEN slots into the GCM pipeline under credit control
module aes_gcm_issue_scheduler
  import aes_gcm_pkg::*;
#(
  parameter int CREDITS = 16
) (
  input logic clk,
  input logic i_rst_n,
  aes_gcm_issue_scheduler_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_AAD, S_PT, S_LEN} state_t;
  state_t state, state_nx;
  block_t j0, cb;
  logic [31:0] aad_cnt, pt_cnt;
  logic [0:63] aad_len, pt_len;
  logic credit_ok, issue, job_hs;
  logic [$clog2(CREDITS+1)-1:0] credit_count;
  phase_t phase_nx;
  aes_gcm_credit_counter #(.CREDITS(CREDITS)) u_credit (
    .clk(clk),
    .rst_n(i_rst_n),
    .consume(issue),
    .credit_return(bus.i_credit_return),
    .count(credit_count),
    .nonzero(credit_ok),
    .err(bus.o_credit_err)
  );
  assign job_hs = state == S_IDLE && bus.i_job_valid;
  assign bus.o_job_ready = state == S_IDLE;
  assign bus.o_data_ready = (state == S_AAD || state == S_PT) && credit_ok;
  assign bus.o_h = '0;
  always_comb begin
    state_nx = state;
    issue = 1'b0;
    case (state)
      S_IDLE: state_nx = bus.i_job_valid ? S_INIT : S_IDLE;
      S_INIT: begin
        issue = credit_ok;
        state_nx = !issue ? S_INIT : aad_cnt != 0 ? S_AAD : pt_cnt != 0 ? S_PT : S_LEN;
      end
      S_AAD: begin
        issue = credit_ok && bus.i_data_valid;
        state_nx = issue && aad_cnt == 32'd1 ? (pt_cnt != 0 ? S_PT : S_LEN) : S_AAD;
      end
      S_PT: begin
        issue = credit_ok && bus.i_data_valid;
        state_nx = issue && pt_cnt == 32'd1 ? S_LEN : S_PT;
      end
      S_LEN: begin
        issue = credit_ok;
        state_nx = issue ? S_IDLE : S_LEN;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  assign phase_nx = !issue ? PH_BUBBLE : state == S_INIT ? PH_INIT : state == S_AAD ? PH_AAD :
                    state == S_PT ? PH_PT : PH_LEN;
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      j0 <= '0;
      cb <= '0;
      aad_cnt <= '0;
      pt_cnt <= '0;
      aad_len <= '0;
      pt_len <= '0;
      bus.o_phase <= PH_BUBBLE;
      bus.o_encrypted_j0 <= '0;
      bus.o_encrypted_cb <= '0;
      bus.o_aad <= '0;
      bus.o_plain_text <= '0;
      bus.o_instance_size <= '0;
    end else begin
      state <= state_nx;
      if (job_hs) begin
        j0 <= {bus.i_job_iv, J0_SUFFIX};
        cb <= inc32({bus.i_job_iv, J0_SUFFIX});
        aad_cnt <= blocks(bus.i_job_aad_len_bits);
        pt_cnt <= blocks(bus.i_job_pt_len_bits);
        aad_len <= bus.i_job_aad_len_bits;
        pt_len <= bus.i_job_pt_len_bits;
      end
      if (phase_nx == PH_AAD) aad_cnt <= aad_cnt - 32'd1;
      if (phase_nx == PH_PT) begin
        pt_cnt <= pt_cnt - 32'd1;
        cb <= inc32(cb);
      end
      bus.o_phase <= phase_nx;
      bus.o_encrypted_j0 <= phase_nx == PH_INIT ? j0 : '0;
      bus.o_encrypted_cb <= phase_nx == PH_PT ? cb : '0;
      bus.o_aad <= phase_nx == PH_AAD ? bus.i_data : '0;
      bus.o_plain_text <= phase_nx == PH_PT ? bus.i_data : '0;
      bus.o_instance_size <= phase_nx == PH_LEN ? {aad_len, pt_len} : '0;
    end
  end
endmodule
